icache: RTL and testbench



---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_array.sv | 40 ++++
 rtl/icache.sv | 109 ++++++++++
 tb/tb_icache.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared geometry and FSM state encodings for the instruction cache
package icache_pkg;

  localparam int IDX_W  = 6;
  localparam int ADDR_W = 18;
  localparam int TAG_W  = ADDR_W - 2 - IDX_W;
  localparam int LINES  = 1 << IDX_W;

  localparam logic [1:0] IC_IDLE  = 2'd0;
  localparam logic [1:0] IC_MISS  = 2'd1;
  localparam logic [1:0] IC_DRAIN = 2'd2;
  localparam logic [1:0] IC_RESP  = 2'd3;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped valid/tag/data store, one fill port, one combinational read port
module icache_array
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

  // Only the valid bits need reset; tag/data are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - instruction cache FSM between IF and MemCtl; ICACHE_STAT_EN adds hit/miss counters
module icache
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  input  logic        jal_reset,
  output logic        if_ret_flg,
  output logic [31:0] if_ret_ins,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_ins
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  logic [1:0]  state;
  logic        hit;
  logic [31:0] rd_data;
  logic        fill;
  logic        accept;
  logic [1:0]  unused_pc_lsb;

  assign unused_pc_lsb = if_pc[1:0];
  assign accept = (state == IC_IDLE) && if_req && !jal_reset;
  // mem_addr doubles as the latched miss address, so the fill indexes from it.
  assign fill = rdy && mem_done && ((state == IC_MISS) || (state == IC_DRAIN));

  icache_array u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (if_pc[IDX_W+1:2]),
    .rd_tag  (if_pc[ADDR_W-1:IDX_W+2]),
    .hit     (hit),
    .rd_data (rd_data),
    .wr_en   (fill),
    .wr_idx  (mem_addr[IDX_W+1:2]),
    .wr_tag  (mem_addr[ADDR_W-1:IDX_W+2]),
    .wr_data (mem_ins)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IC_IDLE;
      if_ret_flg <= 1'b0;
      if_ret_ins <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else if (rdy) begin
      if_ret_flg <= 1'b0;
      case (state)
        IC_IDLE: begin
          if (accept) begin
            if (hit) begin
              if_ret_flg <= 1'b1;
              if_ret_ins <= rd_data;
              state      <= IC_RESP;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= {if_pc[31:2], 2'b00};
              state    <= IC_MISS;
            end
          end
        end
        IC_MISS: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            if (jal_reset) begin
              state <= IC_IDLE;
            end else begin
              if_ret_flg <= 1'b1;
              if_ret_ins <= mem_ins;
              state      <= IC_RESP;
            end
          end else if (jal_reset) begin
            state <= IC_DRAIN;
          end
        end
        IC_DRAIN: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            state   <= IC_IDLE;
          end
        end
        default: state <= IC_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy && accept) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache: misses, hits, conflicts, flush, freeze, reset
module tb_icache;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, jal_reset, mem_done;
  logic [31:0] if_pc, mem_ins;
  logic        if_ret_flg, mem_req;
  logic [31:0] if_ret_ins, mem_addr;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .if_req     (if_req),
    .if_pc      (if_pc),
    .jal_reset  (jal_reset),
    .if_ret_flg (if_ret_flg),
    .if_ret_ins (if_ret_ins),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_done   (mem_done),
    .mem_ins    (mem_ins)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'hAAAA_AAAA;
      32'h104: return 32'hBBBB_BBBB;
      default: return 32'hC0DE_0000 | {16'd0, a[15:0]};
    endcase
  endfunction

  // Scoreboard: every response pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (if_ret_flg === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_ret", 32'd1, 32'd0);
      else chk("ret_ins", if_ret_ins, exp_q.pop_front());
    end
  end

  task automatic fetch(input logic [31:0] pc, input logic miss, input logic flush, input logic freeze);
    logic [31:0] word;
    logic [31:0] line;
    word = mem_word(pc & 32'h0003_FFFC);
    line = {pc[31:2], 2'b00};
    if (!flush) exp_q.push_back(word);
    @(posedge clk); #1;
    if_req = 1'b1;
    if_pc  = pc;
    @(posedge clk); #1;
    if (!miss) begin
      chk("hit_mem_req", {31'd0, mem_req}, 32'd0);
      chk("hit_flg", {31'd0, if_ret_flg}, 32'd1);
      if_req = 1'b0;
    end else begin
      chk("miss_mem_req", {31'd0, mem_req}, 32'd1);
      chk("miss_addr", mem_addr, line);
      chk("miss_no_flg", {31'd0, if_ret_flg}, 32'd0);
      if (flush) begin
        jal_reset = 1'b1;
        if_req    = 1'b0;
      end
      for (int k = 1; k < MEM_LAT; k++) begin
        @(posedge clk); #1;
        jal_reset = 1'b0;
        if (freeze && k == 1) begin
          rdy = 1'b0;
          repeat (5) begin
            @(posedge clk); #1;
            chk("frz_req", {31'd0, mem_req}, 32'd1);
            chk("frz_addr", mem_addr, line);
          end
          rdy = 1'b1;
        end
        chk("wait_req", {31'd0, mem_req}, 32'd1);
      end
      mem_done = 1'b1;
      mem_ins  = word;
      @(posedge clk); #1;
      mem_done = 1'b0;
      mem_ins  = '0;
      if_req   = 1'b0;
      chk("fill_drop_req", {31'd0, mem_req}, 32'd0);
      chk("fill_flg", {31'd0, if_ret_flg}, {31'd0, !flush});
    end
    @(posedge clk); #1;
    chk("resp_end", {31'd0, if_ret_flg}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; jal_reset = 1'b0;
    mem_done = 1'b0; if_pc = '0; mem_ins = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flg", {31'd0, if_ret_flg}, 32'd0);
    chk("rst_ins", if_ret_ins, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst = 1'b0;

    fetch(32'h0, 1'b1, 1'b0, 1'b0);
    fetch(32'h0, 1'b0, 1'b0, 1'b0);
    fetch(32'h4, 1'b1, 1'b0, 1'b0);
    fetch(32'h104, 1'b1, 1'b0, 1'b0);
    fetch(32'h4, 1'b1, 1'b0, 1'b0);
`ifdef ICACHE_STAT_EN
    chk("hit_cnt", hit_cnt, 32'd1);
    chk("miss_cnt", miss_cnt, 32'd4);
`endif
    fetch(32'h0004_0004, 1'b0, 1'b0, 1'b0);

    fetch(32'h8, 1'b1, 1'b1, 1'b0);
    fetch(32'h8, 1'b0, 1'b0, 1'b0);

    fetch(32'h10, 1'b1, 1'b0, 1'b1);
    fetch(32'h10, 1'b0, 1'b0, 1'b0);

    @(posedge clk); #1;
    if_req = 1'b1; if_pc = 32'h10; jal_reset = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b0; jal_reset = 1'b0;
    chk("jal_drop_flg", {31'd0, if_ret_flg}, 32'd0);
    chk("jal_drop_req", {31'd0, mem_req}, 32'd0);

    mem_done = 1'b1; mem_ins = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_done = 1'b0; mem_ins = '0;
    chk("stray_done_req", {31'd0, mem_req}, 32'd0);
    fetch(32'h10, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(32'h0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
